// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and address helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    // Clears the low offset bits that a half or word access cannot use.
    function automatic logic [1:0] f3_align(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: byte enables, store-data replication and load extraction.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    always_comb begin
        byte_v    = rdata[{addr, 3'b000} +: 8];
        half_v    = rdata[{addr[1], 4'b0000} +: 16];
        sext      = ~funct3[2];
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sext & byte_v[7]}}, byte_v};
            end
            2'b01: begin
                be        = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sext & half_v[15]}}, half_v};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: req/ack data-memory handshake with timeout and lane steering.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ls_valid,
    input  logic          ls_we,
    input  logic [2:0]    ls_funct3,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_busy,
    output logic          ls_done,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic          misalign
`endif
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t    state;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [1:0]    lo_q;
    logic [CW-1:0] cnt;

    logic          illegal_now;
    logic          mis_now;
    logic [1:0]    lo_now;
    logic [2:0]    lane_f3;
    logic [1:0]    lane_lo;
    logic [3:0]    lane_be;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] lane_rdata;

    assign illegal_now = f3_illegal(ls_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_now = f3_misaligned(ls_funct3, ls_addr[1:0]) & ~illegal_now;
    assign lo_now  = ls_addr[1:0];
`else
    assign mis_now = 1'b0;
    assign lo_now  = f3_align(ls_funct3, ls_addr[1:0]);
`endif

    // Lanes see the live request in IDLE and the captured one while the access is in flight.
    assign lane_f3 = (state == IDLE) ? ls_funct3 : funct3_q;
    assign lane_lo = (state == IDLE) ? lo_now    : lo_q;

    lsu_lane u_lane (
        .funct3    (lane_f3),
        .addr      (lane_lo),
        .wdata     (ls_wdata),
        .rdata     (mem_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Busy drops in DONE so the core advances on the same edge that ends the access.
    assign ls_busy   = (state == REQ) | ((state == IDLE) & ls_valid);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            lo_q      <= 2'b00;
            cnt       <= '0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
        end else begin
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ls_valid) begin
                        we_q      <= ls_we;
                        funct3_q  <= ls_funct3;
                        lo_q      <= lo_now;
                        cnt       <= '0;
                        mem_addr  <= {ls_addr[AW-1:2], 2'b00};
                        mem_be    <= lane_be;
                        mem_wdata <= lane_wdata;
                        if (illegal_now || mis_now) begin
                            state    <= DONE;
                            ls_done  <= 1'b1;
                            ls_err   <= 1'b1;
                            ls_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign <= mis_now;
`endif
                        end else begin
                            state   <= REQ;
                            mem_req <= 1'b1;
                            mem_we  <= ls_we;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        ls_done  <= 1'b1;
                        ls_rdata <= we_q ? '0 : lane_rdata;
                    end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        ls_done  <= 1'b1;
                        ls_err   <= 1'b1;
                        ls_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ls_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if with a word-array memory responder and an expected-result queue.
module tb_lsu_mem_if;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_valid, ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_busy, ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:63];
    logic [31:0] exp_q[$];
    logic        err_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    lsu_mem_if #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ls_valid(ls_valid), .ls_we(ls_we), .ls_funct3(ls_funct3),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_busy(ls_busy), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic int acc_off(input logic [2:0] f3, input logic [31:0] addr);
        int sz = acc_size(f3);
        return int'(addr[1:0]) - (int'(addr[1:0]) % sz);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be = 4'b0000;
        for (int i = 0; i < acc_size(f3); i++) be[acc_off(f3, addr) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wrep(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz = acc_size(f3);
        for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] addr);
        logic [31:0] v;
        int sz = acc_size(f3);
        v = word >> (8 * acc_off(f3, addr));
        if (sz < 4) begin
            v = v & ((32'd1 << (8 * sz)) - 32'd1);
            if (!f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        end
        return v;
    endfunction

    // driver: one access, playing the memory; delay < 0 means the memory never acks
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay, input logic [31:0] exp_r,
                         input logic exp_e, input int exp_lat);
        int lat = 0;
        int waited = 0;
        bit done_seen = 0;
        logic [31:0] got_r;
        logic got_e;
        exp_q.push_back(exp_r);
        err_q.push_back(exp_e);
        @(negedge clk);
        ls_valid = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
        #1 check("busy_on_valid", {31'd0, ls_busy}, 32'd1);
        while (!done_seen && lat < 40) begin
            @(negedge clk);
            lat++;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (ls_done) begin
                done_seen = 1;
                got_r = exp_q.pop_front();
                got_e = err_q.pop_front();
                check("latency", lat, exp_lat);
                check("ls_err", {31'd0, ls_err}, {31'd0, got_e});
                check("ls_rdata", ls_rdata, got_r);
                check("busy_in_done", {31'd0, ls_busy}, 32'd0);
                check("req_in_done", {31'd0, mem_req}, 32'd0);
                ls_valid = 1'b0;
            end else if (mem_req) begin
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_we", {31'd0, mem_we}, {31'd0, we});
                check("mem_be", {28'd0, mem_be}, {28'd0, model_be(f3, addr)});
                if (we) check("mem_wdata", mem_wdata, model_wrep(f3, wd));
                check("busy_in_req", {31'd0, ls_busy}, 32'd1);
                if (delay >= 0 && waited == delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        for (int j = 0; j < 4; j++)
                            if (mem_be[j]) mem[mem_addr[7:2]][8*j +: 8] = mem_wdata[8*j +: 8];
                    end else begin
                        mem_rdata = mem[mem_addr[7:2]];
                    end
                end
                waited++;
            end
        end
        check("done_seen", {31'd0, done_seen}, 32'd1);
        @(negedge clk);
        mem_ack = 1'b0;
        check("done_one_cycle", {31'd0, ls_done}, 32'd0);
        check("err_one_cycle", {31'd0, ls_err}, 32'd0);
        check("back_idle", {30'd0, dbg_state}, 32'(IDLE));
        check("req_after", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input int delay,
                        input logic [31:0] exp_r);
        issue(1'b0, f3, addr, 32'd0, delay, exp_r, 1'b0, delay + 2);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input int delay);
        issue(1'b1, f3, addr, wd, delay, 32'd0, 1'b0, delay + 2);
    endtask

    initial begin
        logic [2:0]  ld_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        logic [2:0]  st_f3 [3] = '{F3_SB, F3_SH, F3_SW};
        logic [2:0]  f3;
        logic [31:0] a, wd, w;
        int          d;

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        reset = 1'b1; ls_valid = 1'b0; ls_we = 1'b0; ls_funct3 = 3'b000;
        ls_addr = '0; ls_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_busy", {31'd0, ls_busy}, 32'd0);
        check("rst_done", {31'd0, ls_done}, 32'd0);
        check("rst_err", {31'd0, ls_err}, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata", ls_rdata, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'(IDLE));
        reset = 1'b0;

        // word store, zero wait
        store(F3_SW, 32'h64, 32'h12345678, 0);
        check("sw_mem", mem[32'h64 >> 2], 32'h12345678);

        // sign/zero extension
        mem[32'h40 >> 2] = 32'h80F07F01;
        load(F3_LB,  32'h43, 0, 32'hFFFFFF80);
        load(F3_LBU, 32'h43, 0, 32'h00000080);
        load(F3_LH,  32'h42, 1, 32'hFFFF80F0);
        load(F3_LHU, 32'h40, 0, 32'h00007F01);
        // misaligned half/word are aligned down
        load(F3_LH,  32'h43, 0, 32'hFFFF80F0);
        load(F3_LW,  32'h41, 0, 32'h80F07F01);

        // byte store lane
        mem[32'h60 >> 2] = 32'h11223344;
        store(F3_SB, 32'h61, 32'h000000AB, 0);
        load(F3_LW, 32'h60, 0, 32'h1122AB44);
        store(F3_SH, 32'h62, 32'h0000BEEF, 2);
        load(F3_LW, 32'h60, 0, 32'hBEEFAB44);

        // wait states
        load(F3_LW, 32'h64, 3, 32'h12345678);

        // timeouts on load and store
        issue(1'b0, F3_LW, 32'h40, 32'd0, -1, 32'd0, 1'b1, TO + 1);
        w = mem[32'h44 >> 2];
        issue(1'b1, F3_SW, 32'h44, 32'hDEADBEEF, -1, 32'd0, 1'b1, TO + 1);
        check("to_store_mem", mem[32'h44 >> 2], w);

        // illegal funct3 never reaches memory
        issue(1'b0, 3'b011, 32'h40, 32'd0, 0, 32'd0, 1'b1, 1);
        issue(1'b1, 3'b111, 32'h40, 32'd0, 0, 32'd0, 1'b1, 1);

        // ack outside REQ is ignored
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        check("stray_ack_state", {30'd0, dbg_state}, 32'(IDLE));
        check("stray_ack_done", {31'd0, ls_done}, 32'd0);

        // reset mid-access
        @(negedge clk);
        ls_valid = 1'b1; ls_we = 1'b0; ls_funct3 = F3_LW; ls_addr = 32'h64;
        @(negedge clk);
        check("mid_in_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; ls_valid = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_busy", {31'd0, ls_busy}, 32'd0);
        check("mid_rst_done", {31'd0, ls_done}, 32'd0);
        check("mid_rst_state", {30'd0, dbg_state}, 32'(IDLE));
        @(negedge clk); reset = 1'b0;
        load(F3_LW, 32'h64, 1, 32'h12345678);

        // random legal traffic
        for (int n = 0; n < 40; n++) begin
            a = 32'($urandom_range(0, 255));
            d = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                f3 = st_f3[$urandom_range(0, 2)];
                wd = $urandom;
                store(f3, a, wd, d);
            end else begin
                f3 = ld_f3[$urandom_range(0, 4)];
                load(f3, a, d, model_load(mem[a[7:2]], f3, a));
            end
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
